gray_ptr_receiver: RTL and testbench
====================================

Name: gray_ptr_receiver

Overview:
- Receive end of the async FIFO pointer-crossing path. The binary_to_gray converter is the transmit end; this block is the other side.
- Takes a Gray-coded pointer launched from the opposite clock domain and synchronizes it through a flop chain.
- Decodes the synchronized Gray value back to binary and computes the FIFO fill level and empty flag against the local binary pointer.
- Flags illegal Gray steps and impossible fill levels for debug.

Parameters:
- n, 4, FIFO address width; pointers are n+1 bits (extra wrap bit).
- sync_stages, 2, number of synchronizer flops; legal range 2..4.

Ports:
- clk  input  1  local-domain clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- gray_in  input  n+1  Gray pointer from the remote domain; asynchronous to clk.
- local_ptr  input  n+1  local binary pointer in the clk domain (e.g. read pointer).
- gray_sync  output  n+1  last synchronizer stage.
- bin_ptr  output  n+1  registered binary decode of gray_sync.
- level  output  n+1  registered (bin_ptr - local_ptr) mod 2^(n+1).
- empty  output  1  registered; 1 when level==0 or out_valid==0.
- out_valid  output  1  high once the pipeline holds post-reset data.
- step_err  output  1  sticky; a Gray step changed more than 1 bit.
- level_err  output  1  sticky; computed level exceeded 2^n.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst: sampled only on the rising edge of clk.
- Reset state, taking effect at the first clk edge with rst=1:
  - All sync stages, gray_sync, bin_ptr and level = 0.
  - empty = 1; out_valid, step_err, level_err = 0.
  - Internal warm-up counter = 0.
- Synchronizer:
  - s[0] <= gray_in; s[i] <= s[i-1].
  - gray_sync = s[sync_stages-1].
  - No logic between stages.
- Decode stage, registered, one cycle after gray_sync:
  - b[n] = g[n]; b[i] = b[i+1] ^ g[i] for i = n-1 down to 0.
  - bin_ptr <= decode(gray_sync).
  - level <= decode(gray_sync) - local_ptr, computed modulo 2^(n+1), wrap-around natural.
  - empty <= (that difference == 0) or (warm-up not complete).
- Latency:
  - gray_in stable before edge 0 appears on gray_sync after edge sync_stages-1.
  - It appears on bin_ptr, level and empty after edge sync_stages.
  - Total: sync_stages+1 edges.
- local_ptr is sampled same-cycle into level; no extra delay.
- Warm-up:
  - A counter increments each cycle after reset until it reaches sync_stages+1, then saturates.
  - out_valid = 1 once saturated.
  - While out_valid = 0: level is held at 0, empty at 1, and both error detectors are disabled.
- step_err:
  - When out_valid = 1 and popcount(gray_sync ^ previous gray_sync) > 1, step_err is set on the next edge.
  - Previous gray_sync is held in an internal register.
  - Zero-bit and one-bit changes are legal.
- level_err: when out_valid = 1 and the computed difference > 2^n, level_err is set on the same edge level updates.
- Error flags are sticky; only rst clears them.
- level == 2^n is legal (FIFO full from this side) and does not set level_err.
- Wrap:
  - Pointer wrap from 2^(n+1)-1 to 0 is a single Gray step (bits 10000 -> 00000 for n=4) and is legal.
  - level computes correctly across the wrap.
- Reset mid-operation:
  - rst dominates every other input.
  - The pipeline is flushed, out_valid drops on the next edge, and warm-up restarts on the first edge with rst = 0.
- If local_ptr and gray_in change in the same cycle, no special priority applies: level uses the current local_ptr and the delayed remote pointer. This conservative lag is the intended behaviour.

Test Plan (n=4, sync_stages=2):
1. Reset hold, then rst=0 with gray_in=0, local_ptr=0 -> empty=1 throughout; out_valid rises on the 3rd edge after reset release; level=0.
2. Warm, then gray_in steps 00000 -> 00001 -> 00011 (binary 0,1,2) with local_ptr=0 -> bin_ptr=1 three edges after the first step, then 2; level=2; empty=0.
3. Walk gray_in through all 32 codes incrementing, with local_ptr tracking remote minus 3 -> level constant 3 across the wrap 10000 -> 00000; step_err and level_err stay 0.
4. gray_in jumps 00000 -> 00011 (two bits) -> step_err=1 one edge after gray_sync shows 00011; flag stays 1 until rst.
5. gray_in = binary 17 (Gray 11001) with local_ptr=0 -> level=17 > 16, level_err=1; with binary 16 (Gray 11000) -> level=16, no error.
6. Assert rst mid-stream with level=5 -> next edge: level=0, empty=1, out_valid=0, sticky errors cleared; recovery follows scenario 1 timing.

Source files
------------

// File: rtl/gray_ptr_receiver.sv
// Receive end of the async FIFO pointer crossing: synchronizes a remote Gray
// pointer, decodes it to binary and derives fill level, empty and debug flags.
module gray_ptr_receiver #(
  parameter int n           = 4,
  parameter int sync_stages = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [n:0] gray_in,
  input  logic [n:0] local_ptr,
  output logic [n:0] gray_sync,
  output logic [n:0] bin_ptr,
  output logic [n:0] level,
  output logic       empty,
  output logic       out_valid,
  output logic       step_err,
  output logic       level_err
);

  localparam logic [2:0] warm_max  = 3'(sync_stages + 1);
  localparam logic [2:0] warm_load = 3'(sync_stages);
  localparam logic [n:0] level_max = {1'b1, {n{1'b0}}};

  logic [n:0] s [sync_stages];
  logic [n:0] prev_gray;
  logic [2:0] warm_cnt;
  logic [n:0] bin_next;
  logic [n:0] diff;
  logic [n:0] gray_delta;
  logic       load;
  logic       multi_bit;

  always_comb begin
    bin_next    = '0;
    bin_next[n] = gray_sync[n];
    for (int i = n - 1; i >= 0; i--) begin
      bin_next[i] = bin_next[i+1] ^ gray_sync[i];
    end
  end

  assign gray_sync  = s[sync_stages-1];
  assign diff       = bin_next - local_ptr;
  assign gray_delta = gray_sync ^ prev_gray;
  // x & (x-1) clears the lowest set bit; anything left means two or more bits flipped.
  assign multi_bit  = |(gray_delta & (gray_delta - 1'b1));
  // gray_sync first carries post-reset data on the edge the counter reaches
  // sync_stages, so the decode stage loads then and out_valid rises with it.
  assign load       = (warm_cnt >= warm_load);
  assign out_valid  = (warm_cnt == warm_max);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < sync_stages; i++) s[i] <= '0;
      prev_gray <= '0;
      warm_cnt  <= '0;
      bin_ptr   <= '0;
      level     <= '0;
      empty     <= 1'b1;
      step_err  <= 1'b0;
      level_err <= 1'b0;
    end else begin
      s[0] <= gray_in;
      for (int i = 1; i < sync_stages; i++) s[i] <= s[i-1];
      prev_gray <= gray_sync;
      if (warm_cnt != warm_max) warm_cnt <= warm_cnt + 3'd1;
      bin_ptr <= bin_next;
      if (load) begin
        level <= diff;
        empty <= (diff == '0);
        if (diff > level_max) level_err <= 1'b1;
      end else begin
        level <= '0;
        empty <= 1'b1;
      end
      if (out_valid && multi_bit) step_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gray_ptr_receiver.sv
// Directed bench for gray_ptr_receiver (n=4, sync_stages=2).
module tb_gray_ptr_receiver;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] gray_in;
  logic [4:0] local_ptr;
  logic [4:0] gray_sync;
  logic [4:0] bin_ptr;
  logic [4:0] level;
  logic       empty;
  logic       out_valid;
  logic       step_err;
  logic       level_err;

  int checks   = 0;
  int failures = 0;

  gray_ptr_receiver #(.n(4), .sync_stages(2)) dut (
    .clk(clk), .rst(rst), .gray_in(gray_in), .local_ptr(local_ptr),
    .gray_sync(gray_sync), .bin_ptr(bin_ptr), .level(level), .empty(empty),
    .out_valid(out_valid), .step_err(step_err), .level_err(level_err)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] to_gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic tick(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // reset, release with gray_in=0/local_ptr=0 and run the 3 warm-up edges
  task automatic restart();
    rst = 1'b1; gray_in = '0; local_ptr = '0;
    tick(2);
    rst = 1'b0;
    tick(3);
  endtask

  task automatic test_reset();
    rst = 1'b1; gray_in = '0; local_ptr = '0;
    tick(2);
    checks++;
    if (gray_sync !== 5'd0 || bin_ptr !== 5'd0 || level !== 5'd0 || empty !== 1'b1 ||
        out_valid !== 1'b0 || step_err !== 1'b0 || level_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: gs=%b bin=%0d lvl=%0d e=%b ov=%b se=%b le=%b, want 0,0,0,1,0,0,0",
               gray_sync, bin_ptr, level, empty, out_valid, step_err, level_err);
    end
    rst = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      tick(1);
      checks++;
      if (out_valid !== (e == 3) || empty !== 1'b1 || level !== 5'd0) begin
        failures++;
        $display("FAIL warmup_edge%0d: ov=%b e=%b lvl=%0d, want ov=%b e=1 lvl=0",
                 e, out_valid, empty, level, (e == 3));
      end
    end
  endtask

  task automatic test_count();
    gray_in = 5'b00001;
    tick(2);
    checks++;
    if (gray_sync !== 5'b00001) begin
      failures++;
      $display("FAIL count_gray_sync: got %b want 00001", gray_sync);
    end
    gray_in = 5'b00011;
    tick(1);
    checks++;
    if (bin_ptr !== 5'd1 || level !== 5'd1 || empty !== 1'b0) begin
      failures++;
      $display("FAIL count_first: bin=%0d lvl=%0d e=%b, want 1,1,0", bin_ptr, level, empty);
    end
    tick(2);
    checks++;
    if (bin_ptr !== 5'd2 || level !== 5'd2 || empty !== 1'b0) begin
      failures++;
      $display("FAIL count_second: bin=%0d lvl=%0d e=%b, want 2,2,0", bin_ptr, level, empty);
    end
  endtask

  task automatic test_wrap();
    logic [4:0] r;
    restart();
    for (int i = 0; i < 34; i++) begin
      r = 5'(i);
      gray_in   = to_gray(r);
      local_ptr = r - 5'd3;
      tick(4);
      checks++;
      if (level !== 5'd3 || bin_ptr !== r) begin
        failures++;
        $display("FAIL wrap_r%0d: lvl=%0d bin=%0d, want lvl=3 bin=%0d", i, level, bin_ptr, r);
      end
    end
    checks++;
    if (step_err !== 1'b0 || level_err !== 1'b0) begin
      failures++;
      $display("FAIL wrap_flags: se=%b le=%b, want 0,0", step_err, level_err);
    end
  endtask

  task automatic test_step_err();
    restart();
    gray_in = 5'b00011;
    tick(2);
    checks++;
    if (gray_sync !== 5'b00011 || step_err !== 1'b0) begin
      failures++;
      $display("FAIL step_pre: gs=%b se=%b, want 00011,0", gray_sync, step_err);
    end
    tick(1);
    checks++;
    if (step_err !== 1'b1) begin
      failures++;
      $display("FAIL step_set: se=%b want 1", step_err);
    end
    gray_in = 5'b00010;
    tick(5);
    checks++;
    if (step_err !== 1'b1) begin
      failures++;
      $display("FAIL step_sticky: se=%b want 1", step_err);
    end
  endtask

  task automatic test_level_err();
    restart();
    gray_in = 5'b11000;
    tick(3);
    checks++;
    if (level !== 5'd16 || level_err !== 1'b0 || empty !== 1'b0) begin
      failures++;
      $display("FAIL level_full: lvl=%0d le=%b e=%b, want 16,0,0", level, level_err, empty);
    end
    gray_in = 5'b11001;
    tick(3);
    checks++;
    if (level !== 5'd17 || level_err !== 1'b1) begin
      failures++;
      $display("FAIL level_over: lvl=%0d le=%b, want 17,1", level, level_err);
    end
  endtask

  task automatic test_reset_mid();
    restart();
    gray_in = 5'b00111;
    tick(3);
    checks++;
    if (level !== 5'd5 || step_err !== 1'b1) begin
      failures++;
      $display("FAIL mid_pre: lvl=%0d se=%b, want 5,1", level, step_err);
    end
    rst = 1'b1;
    tick(1);
    checks++;
    if (level !== 5'd0 || empty !== 1'b1 || out_valid !== 1'b0 || step_err !== 1'b0 ||
        level_err !== 1'b0 || gray_sync !== 5'd0) begin
      failures++;
      $display("FAIL mid_reset: lvl=%0d e=%b ov=%b se=%b le=%b gs=%b, want 0,1,0,0,0,00000",
               level, empty, out_valid, step_err, level_err, gray_sync);
    end
    rst = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      tick(1);
      checks++;
      if (out_valid !== (e == 3) || empty !== (e != 3) || level !== ((e == 3) ? 5'd5 : 5'd0)) begin
        failures++;
        $display("FAIL mid_recover_edge%0d: ov=%b e=%b lvl=%0d", e, out_valid, empty, level);
      end
    end
    tick(1);
    checks++;
    if (step_err !== 1'b0) begin
      failures++;
      $display("FAIL mid_no_step: se=%b want 0", step_err);
    end
  endtask

  initial begin
    rst = 1'b1; gray_in = '0; local_ptr = '0;
    #2;
    test_reset();
    test_count();
    test_wrap();
    test_step_err();
    test_level_err();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
